// File: rtl/led_serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// led_serial_rx_pkg
// Shared definitions for the LED serial link receiver: default frame width,
// receiver FSM state encoding and the idle (reset) levels of the four link
// lines as seen by the synchronisers.
// -----------------------------------------------------------------------------
package led_serial_rx_pkg;

    // Default number of LED bits carried per frame
    localparam int LINK_WIDTH = 16;

    // Receiver FSM states
    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // Line levels the link rests at when the transmitter is quiet
    localparam logic IDLE_LVL_CLK = 1'b0;
    localparam logic IDLE_LVL_DO  = 1'b0;
    localparam logic IDLE_LVL_PEN = 1'b1;
    localparam logic IDLE_LVL_CLR = 1'b1;

endpackage : led_serial_rx_pkg

// File: rtl/led_serial_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by an edge
// detector comparing the last synchroniser stage with one extra delayed copy.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (chain resets to IDLE_LEVEL)
//   din    in  asynchronous input line
//   level  out synchronised level
//   rise   out one-cycle pulse on a synchronised 0->1 transition
//   fall   out one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;

    // Synchroniser chain plus one delayed copy of the last stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
            dly_r  <= IDLE_LEVEL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            dly_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level = sync_r[SYNC_STAGES-1];
    assign rise  = sync_r[SYNC_STAGES-1] & ~dly_r;
    assign fall  = ~sync_r[SYNC_STAGES-1] & dly_r;

endmodule : sync_edge

// File: rtl/led_serial_rx.sv
// -----------------------------------------------------------------------------
// led_serial_rx
// Receiving end of the LED serial link. The four link lines are oversampled
// in the clk domain, WIDTH bits are deserialised MSB first on led_clk rising
// edges and the frame is latched on the led_pen rising edge.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   led_clk    in   serial shift clock (async to clk)
//   led_do     in   serial data, sampled on led_clk rise
//   led_pen    in   latch strobe, rising edge ends the frame
//   led_clr    in   active-low clear from the transmitter
//   data       out  last good frame (inverted when INVERT=1)
//   data_valid out  one-cycle pulse when data was updated
//   frame_err  out  one-cycle pulse when a frame ended with wrong bit count
//   busy       out  high while a frame is being shifted in
// -----------------------------------------------------------------------------
module led_serial_rx
    import led_serial_rx_pkg::*;
#(
    parameter int WIDTH       = LINK_WIDTH,
    parameter bit INVERT      = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             led_clk,
    input  logic             led_do,
    input  logic             led_pen,
    input  logic             led_clr,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    // Counter must hold WIDTH+1 (overrun saturation value)
    localparam int              CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    // Synchronised link lines
    logic clk_rise_s;
    logic do_lvl_s;
    logic pen_rise_s;
    logic clr_lvl_s;
    logic [6:0] unused_sync_s;

    // Frame state
    rx_state_e        state_r;
    rx_state_e        state_eff_s;
    rx_state_e        state_next_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_eff_s;
    logic [WIDTH-1:0] sr_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_eff_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Output registers and their next values
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_next_s;
    logic             valid_r;
    logic             valid_next_s;
    logic             err_r;
    logic             err_next_s;
    logic             busy_r;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(IDLE_LVL_CLK)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (led_clk),
        .level (unused_sync_s[0]),
        .rise  (clk_rise_s),
        .fall  (unused_sync_s[1])
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(IDLE_LVL_DO)) u_sync_do (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (led_do),
        .level (do_lvl_s),
        .rise  (unused_sync_s[2]),
        .fall  (unused_sync_s[3])
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(IDLE_LVL_PEN)) u_sync_pen (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (led_pen),
        .level (unused_sync_s[4]),
        .rise  (pen_rise_s),
        .fall  (unused_sync_s[5])
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(IDLE_LVL_CLR)) u_sync_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (led_clr),
        .level (clr_lvl_s),
        .rise  (unused_sync_s[6]),
        .fall  ()
    );

    // Apply a pending shift first so a latch in the same sample sees the updated frame
    always_comb begin
        sr_eff_s    = sr_r;
        cnt_eff_s   = cnt_r;
        state_eff_s = state_r;
        if (clk_rise_s) begin
            sr_eff_s    = {sr_r[WIDTH-2:0], do_lvl_s};
            cnt_eff_s   = (cnt_r >= CNT_SAT) ? CNT_SAT : (cnt_r + CNT_W'(1));
            state_eff_s = RX_SHIFT;
        end else begin
            sr_eff_s    = sr_r;
            cnt_eff_s   = cnt_r;
            state_eff_s = state_r;
        end
    end

    // Next-state and output decode; a low clear line overrides everything
    always_comb begin
        state_next_s = state_r;
        sr_next_s    = sr_r;
        cnt_next_s   = cnt_r;
        data_next_s  = data_r;
        valid_next_s = 1'b0;
        err_next_s   = 1'b0;
        if (!clr_lvl_s) begin
            state_next_s = RX_IDLE;
            sr_next_s    = '0;
            cnt_next_s   = '0;
            data_next_s  = '0;
        end else begin
            sr_next_s  = sr_eff_s;
            cnt_next_s = cnt_eff_s;
            case (state_eff_s)
                RX_IDLE: begin
                    // A strobe with no bits shifted is ignored
                    state_next_s = RX_IDLE;
                end
                RX_SHIFT: begin
                    if (pen_rise_s) begin
                        state_next_s = RX_IDLE;
                        cnt_next_s   = '0;
                        if (cnt_eff_s == CNT_FULL) begin
                            data_next_s  = INVERT ? ~sr_eff_s : sr_eff_s;
                            valid_next_s = 1'b1;
                        end else begin
                            err_next_s = 1'b1;
                        end
                    end else begin
                        state_next_s = RX_SHIFT;
                    end
                end
                default: begin
                    state_next_s = RX_IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    // Frame state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_IDLE;
            sr_r    <= '0;
            cnt_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            sr_r    <= sr_next_s;
            cnt_r   <= cnt_next_s;
            data_r  <= data_next_s;
            valid_r <= valid_next_s;
            err_r   <= err_next_s;
            busy_r  <= (state_next_s == RX_SHIFT);
        end
    end

    assign data       = data_r;
    assign data_valid = valid_r;
    assign frame_err  = err_r;
    assign busy       = busy_r;

endmodule : led_serial_rx

// File: tb/tb_led_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_led_serial_rx
// Drives the LED link into two receivers (INVERT=1 and INVERT=0) sharing the
// same link lines. A reference model keeps the expected last-good word of each
// receiver, derived from the bits sent and the frame length.
// -----------------------------------------------------------------------------
module tb_led_serial_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        led_clk;
    logic        led_do;
    logic        led_pen;
    logic        led_clr;
    logic [15:0] data1;
    logic [15:0] data0;
    logic        dv1, dv0, fe1, fe0, busy1, busy0;

    int checks   = 0;
    int failures = 0;

    // Reference model: last good word for each receiver
    logic [15:0] exp1;
    logic [15:0] exp0;

    // Observations collected around a latch strobe
    int obs_v1, obs_e1, obs_v0, obs_e0, obs_first, obs_both;

    always #5 clk = ~clk;

    led_serial_rx #(.WIDTH(16), .INVERT(1'b1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .led_clk(led_clk), .led_do(led_do),
        .led_pen(led_pen), .led_clr(led_clr), .data(data1),
        .data_valid(dv1), .frame_err(fe1), .busy(busy1)
    );

    led_serial_rx #(.WIDTH(16), .INVERT(1'b0), .SYNC_STAGES(2)) dut_ni (
        .clk(clk), .rst_n(rst_n), .led_clk(led_clk), .led_do(led_do),
        .led_pen(led_pen), .led_clr(led_clr), .data(data0),
        .data_valid(dv0), .frame_err(fe0), .busy(busy0)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        led_do = b;
        tick(2);
        led_clk = 1'b1;
        tick(4);
        led_clk = 1'b0;
        tick(2);
    endtask

    task automatic start_frame();
        led_pen = 1'b0;
        tick(3);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    // Raise PEN (optionally together with a led_clk rise) and watch 12 cycles
    task automatic latch(input bit with_clk);
        led_pen = 1'b1;
        if (with_clk) led_clk = 1'b1;
        obs_v1 = 0; obs_e1 = 0; obs_v0 = 0; obs_e0 = 0; obs_both = 0; obs_first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (dv1 === 1'b1) begin
                obs_v1++;
                if (obs_first < 0) obs_first = i;
            end
            if (fe1 === 1'b1) obs_e1++;
            if (dv0 === 1'b1) obs_v0++;
            if (fe0 === 1'b1) obs_e0++;
            if ((dv1 && fe1) || (dv0 && fe0)) obs_both++;
        end
        if (with_clk) begin
            tick(1);
            led_clk = 1'b0;
            tick(4);
        end
    endtask

    // Model: a frame of n bits updates the word only when exactly 16 arrived
    task automatic model_frame(input logic [31:0] bits, input int n);
        if (n == 16) begin
            exp1 = ~bits[15:0];
            exp0 = bits[15:0];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; led_clk = 1'b0; led_do = 1'b0; led_pen = 1'b1; led_clr = 1'b1;
        exp1 = 16'h0000; exp0 = 16'h0000;
        tick(3);
        checks++;
        if (data1 !== 16'h0000 || data0 !== 16'h0000) begin
            failures++; $display("FAIL reset_data got=%h/%h exp=0000", data1, data0);
        end
        checks++;
        if ({dv1, fe1, busy1, dv0, fe0, busy0} !== 6'b000000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000000", {dv1, fe1, busy1, dv0, fe0, busy0});
        end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_invert_frame();
        logic [31:0] bits;
        bits = {16'h0000, ~16'hA5C3};
        start_frame();
        send_bits(bits, 16);
        checks++;
        if (busy1 !== 1'b1) begin
            failures++; $display("FAIL t1_busy got=%b exp=1", busy1);
        end
        latch(1'b0);
        model_frame(bits, 16);
        checks++;
        if (data1 !== 16'hA5C3) begin
            failures++; $display("FAIL t1_data got=%h exp=%h", data1, 16'hA5C3);
        end
        checks++;
        if (data0 !== exp0) begin
            failures++; $display("FAIL t1_data_noinv got=%h exp=%h", data0, exp0);
        end
        checks++;
        if (obs_v1 != 1 || obs_e1 != 0) begin
            failures++; $display("FAIL t1_pulses got v=%0d e=%0d exp v=1 e=0", obs_v1, obs_e1);
        end
        checks++;
        if (obs_first != 3) begin
            failures++; $display("FAIL t1_latency got=%0d exp=3", obs_first);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            failures++; $display("FAIL t1_busy_end got=%b exp=0", busy1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        words[0] = 32'h0000_0001;
        words[1] = 32'h0000_FFFF;
        for (int k = 0; k < 2; k++) begin
            start_frame();
            send_bits(words[k], 16);
            latch(1'b0);
            model_frame(words[k], 16);
            checks++;
            if (data0 !== words[k][15:0] || obs_v0 != 1) begin
                failures++; $display("FAIL b2b_%0d got=%h v=%0d exp=%h v=1", k, data0, obs_v0, words[k][15:0]);
            end
            checks++;
            if (data1 !== exp1) begin
                failures++; $display("FAIL b2b_inv_%0d got=%h exp=%h", k, data1, exp1);
            end
        end
    endtask

    task automatic test_bad_length();
        int lens [2];
        logic [31:0] bits;
        lens[0] = 15;
        lens[1] = 17;
        for (int k = 0; k < 2; k++) begin
            bits = $urandom();
            start_frame();
            send_bits(bits, lens[k]);
            latch(1'b0);
            checks++;
            if (obs_e1 != 1 || obs_v1 != 0 || obs_e0 != 1 || obs_v0 != 0) begin
                failures++; $display("FAIL badlen_%0d_pulses got e=%0d v=%0d exp e=1 v=0", lens[k], obs_e1, obs_v1);
            end
            checks++;
            if (data1 !== exp1 || data0 !== exp0) begin
                failures++; $display("FAIL badlen_%0d_data got=%h/%h exp=%h/%h", lens[k], data1, data0, exp1, exp0);
            end
        end
    endtask

    task automatic test_idle_pen();
        start_frame();
        latch(1'b0);
        checks++;
        if (obs_v1 != 0 || obs_e1 != 0 || data1 !== exp1) begin
            failures++; $display("FAIL idle_pen got v=%0d e=%0d d=%h exp v=0 e=0 d=%h", obs_v1, obs_e1, data1, exp1);
        end
    endtask

    task automatic test_clear();
        logic [31:0] bits;
        int pulses;
        pulses = 0;
        start_frame();
        send_bits($urandom(), 8);
        led_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (dv1 || fe1 || dv0 || fe0) pulses++;
        end
        tick(1);
        exp1 = 16'h0000; exp0 = 16'h0000;
        checks++;
        if (data1 !== 16'h0000 || data0 !== 16'h0000 || pulses != 0) begin
            failures++; $display("FAIL clr_data got=%h/%h pulses=%0d exp=0000/0000 pulses=0", data1, data0, pulses);
        end
        led_clr = 1'b1;
        tick(4);
        bits = $urandom();
        send_bits(bits, 16);
        latch(1'b0);
        model_frame(bits, 16);
        checks++;
        if (data1 !== exp1 || obs_v1 != 1 || obs_e1 != 0) begin
            failures++; $display("FAIL clr_next got=%h v=%0d e=%0d exp=%h v=1 e=0", data1, obs_v1, obs_e1, exp1);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] bits;
        bits = 32'h0000_1234;
        start_frame();
        send_bits(bits, 16);
        latch(1'b0);
        model_frame(bits, 16);
        start_frame();
        send_bits($urandom(), 6);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data1 !== 16'h0000 || data0 !== 16'h0000 || busy1 !== 1'b0 || dv1 !== 1'b0) begin
            failures++; $display("FAIL async_rst got=%h/%h busy=%b exp=0000/0000 busy=0", data1, data0, busy1);
        end
        led_clk = 1'b0; led_do = 1'b0; led_pen = 1'b1; led_clr = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        exp1 = 16'h0000; exp0 = 16'h0000;
        bits = $urandom();
        start_frame();
        send_bits(bits, 16);
        latch(1'b0);
        model_frame(bits, 16);
        checks++;
        if (data1 !== exp1 || data0 !== exp0 || obs_v1 != 1) begin
            failures++; $display("FAIL async_next got=%h v=%0d exp=%h v=1", data1, obs_v1, exp1);
        end
    endtask

    task automatic test_same_sample();
        logic [31:0] bits;
        bits = $urandom();
        bits[0] = 1'b1;
        start_frame();
        send_bits(bits >> 1, 15);
        led_do = bits[0];
        tick(2);
        latch(1'b1);
        model_frame(bits, 16);
        checks++;
        if (obs_v1 != 1 || obs_e1 != 0) begin
            failures++; $display("FAIL same_pulses got v=%0d e=%0d exp v=1 e=0", obs_v1, obs_e1);
        end
        checks++;
        if (data0 !== exp0 || data1 !== exp1) begin
            failures++; $display("FAIL same_data got=%h exp=%h", data0, exp0);
        end
    endtask

    task automatic test_random();
        logic [31:0] bits;
        int n;
        for (int k = 0; k < 10; k++) begin
            bits = $urandom();
            n = $urandom_range(18, 14);
            start_frame();
            send_bits(bits, n);
            latch(1'b0);
            model_frame(bits, n);
            checks++;
            if (obs_v1 != ((n == 16) ? 1 : 0) || obs_e1 != ((n == 16) ? 0 : 1) || obs_both != 0) begin
                failures++; $display("FAIL rand_%0d_pulses n=%0d got v=%0d e=%0d both=%0d", k, n, obs_v1, obs_e1, obs_both);
            end
            checks++;
            if (data1 !== exp1 || data0 !== exp0) begin
                failures++; $display("FAIL rand_%0d_data n=%0d got=%h/%h exp=%h/%h", k, n, data1, data0, exp1, exp0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_invert_frame();
        test_back_to_back();
        test_bad_length();
        test_idle_pen();
        test_clear();
        test_async_reset();
        test_same_sample();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_led_serial_rx
